// File: rtl/axi_rd_burst_split.sv
// AXI read burst splitter: turns one upstream read burst into a sequence of
// single-beat downstream reads, one outstanding at a time, and replays each
// downstream beat upstream with the burst ID and the proper RLAST.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an upstream AR; o_arready high
// ADDR   | presenting the current beat address downstream (o_m_arvalid)
// DATA   | waiting for the downstream beat (o_m_rready)
// RESP   | holding the captured beat upstream (o_rvalid) until accepted
module axi_rd_burst_split #(
  parameter int ID_WIDTH = 1,
  parameter int AW       = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // upstream AR
  input  logic [ID_WIDTH-1:0] i_arid,
  input  logic [AW-1:0]       i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  // upstream R
  output logic [ID_WIDTH-1:0] o_rid,
  output logic [63:0]         o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready,
  // downstream AR
  output logic [ID_WIDTH-1:0] o_m_arid,
  output logic [AW-1:0]       o_m_araddr,
  output logic [7:0]          o_m_arlen,
  output logic [2:0]          o_m_arsize,
  output logic [1:0]          o_m_arburst,
  output logic                o_m_arvalid,
  input  logic                i_m_arready,
  // downstream R
  input  logic [63:0]         i_m_rdata,
  input  logic [1:0]          i_m_rresp,
  input  logic                i_m_rvalid,
  output logic                o_m_rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [63:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic [8:0]          beats_w;
  logic [AW-1:0]       bytes_w;
  logic [AW-1:0]       span_w;
  logic [AW-1:0]       wrap_mask;
  logic [AW-1:0]       next_addr;
  logic                last_beat;

  assign last_beat = (cnt_q == len_q);

  // Address of the following beat; size_q is already clamped to 8 bytes.
  always_comb begin
    beats_w   = {1'b0, len_q} + 9'd1;
    bytes_w   = ONE << size_q;
    span_w    = {{(AW-9){1'b0}}, beats_w} << size_q;
    wrap_mask = span_w - ONE;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + bytes_w) & wrap_mask);
      default: next_addr = (addr_q & ~(bytes_w - ONE)) + bytes_w;
    endcase
  end

  // Next-state and datapath for the four-state sequencer.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      S_IDLE: begin
        if (i_arvalid) begin
          id_d    = i_arid;
          addr_d  = i_araddr;
          len_d   = i_arlen;
          size_d  = (i_arsize > 3'd3) ? 3'd3 : i_arsize;
          burst_d = i_arburst;
          cnt_d   = 8'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_m_arready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_m_rvalid) begin
          rdata_d = i_m_rdata;
          rresp_d = i_m_rresp;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            // cnt_q < len_q here, so the 8-bit counter never wraps
            cnt_d   = cnt_q + 8'd1;
            addr_d  = next_addr;
            state_d = S_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any burst in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      burst_q <= 2'b00;
      cnt_q   <= 8'd0;
      rdata_q <= 64'd0;
      rresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // Handshake strobes are pure state decodes, so they hold while stalled.
  // o_arready is also gated by reset so nothing is accepted in that cycle.
  assign o_arready   = (state_q == S_IDLE) & ~i_rst;
  assign o_m_arvalid = (state_q == S_ADDR);
  assign o_m_rready  = (state_q == S_DATA);
  assign o_rvalid    = (state_q == S_RESP);

  assign o_rid       = id_q;
  assign o_rdata     = rdata_q;
  assign o_rresp     = rresp_q;
  assign o_rlast     = (state_q == S_RESP) & last_beat;

  assign o_m_arid    = id_q;
  assign o_m_araddr  = addr_q;
  assign o_m_arlen   = 8'd0;
  assign o_m_arsize  = size_q;
  assign o_m_arburst = 2'b01;

endmodule

// File: tb/tb_axi_rd_burst_split.sv
module tb_axi_rd_burst_split;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [0:0]  i_arid;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic [1:0]  i_arburst;
  logic        i_arvalid;
  logic        o_arready;
  logic [0:0]  o_rid;
  logic [63:0] o_rdata;
  logic [1:0]  o_rresp;
  logic        o_rlast;
  logic        o_rvalid;
  logic        i_rready;
  logic [0:0]  o_m_arid;
  logic [31:0] o_m_araddr;
  logic [7:0]  o_m_arlen;
  logic [2:0]  o_m_arsize;
  logic [1:0]  o_m_arburst;
  logic        o_m_arvalid;
  logic        i_m_arready;
  logic [63:0] i_m_rdata;
  logic [1:0]  i_m_rresp;
  logic        i_m_rvalid;
  logic        o_m_rready;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  axi_rd_burst_split #(.ID_WIDTH(1), .AW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready),
    .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen),
    .o_m_arsize(o_m_arsize), .o_m_arburst(o_m_arburst), .o_m_arvalid(o_m_arvalid),
    .i_m_arready(i_m_arready), .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp),
    .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready)
  );

  // Address of the beat after 'a' under the AXI burst rules (32-bit space).
  function automatic logic [31:0] model_next(input logic [31:0] a, input int len,
                                             input int sz, input logic [1:0] b);
    longint unsigned aa, bytes, span;
    aa    = a;
    bytes = 64'd1 << sz;
    if (b == 2'b00) return a;
    if (b == 2'b10) begin
      span = ((longint'(len) + 1) << sz) - 1;
      return 32'((aa & ~span) | ((aa + bytes) & span));
    end
    return 32'((((aa / bytes) * bytes) + bytes) % 64'h1_0000_0000);
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_arvalid = 1'b0; i_rready = 1'b0; i_m_arready = 1'b0;
    i_m_rvalid = 1'b0; i_arid = 1'b0; i_araddr = '0; i_arlen = '0;
    i_arsize = '0; i_arburst = '0; i_m_rdata = '0; i_m_rresp = '0;
    repeat (2) @(negedge i_clk);
    total++; if (o_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", o_rvalid); end
    total++; if (o_rlast !== 1'b0) begin bad++; $display("FAIL rst_rlast got=%b exp=0", o_rlast); end
    total++; if (o_m_arvalid !== 1'b0) begin bad++; $display("FAIL rst_m_arvalid got=%b exp=0", o_m_arvalid); end
    total++; if (o_m_rready !== 1'b0) begin bad++; $display("FAIL rst_m_rready got=%b exp=0", o_m_rready); end
    total++; if (o_rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", o_rdata); end
    total++; if (o_rresp !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b exp=0", o_rresp); end
    total++; if (o_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", o_arready); end
    i_rst = 1'b0;
    @(negedge i_clk);
    total++; if (o_arready !== 1'b1) begin bad++; $display("FAIL post_rst_arready got=%b exp=1", o_arready); end
  endtask

  // Drives one burst end to end and checks every downstream AR and upstream R
  // beat against the reference. Starts and ends at a falling edge.
  task automatic run_burst(input logic [0:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int stall_beat,
                           input int stall_cycles, input int err_beat, input int abort_beat,
                           input bit rnd, input bit hold_ar);
    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] a;
    logic [63:0] prev_data;
    logic [1:0]  prev_resp;
    logic        prev_last;
    bit prev_hold, pend, clr_mr, clr_ar, finished, aborted, seen_ar;
    int eff, n, ar_cnt, r_cnt, cyc, hs_cyc, hs_cnt, stall_left, dly, nvalid;
    eff = (size > 3) ? 3 : size;
    n = len + 1;
    a = addr;
    prev_hold = 0; pend = 0; clr_mr = 0; clr_ar = 0; finished = 0; aborted = 0; seen_ar = 0;
    ar_cnt = 0; r_cnt = 0; cyc = 0; hs_cyc = -10; hs_cnt = 0; stall_left = stall_cycles; dly = 0;
    prev_data = '0; prev_resp = '0; prev_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(a);
      a = model_next(a, len, eff, burst);
    end
    i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arlen = len[7:0];
    i_arsize = size[2:0]; i_arburst = burst;
    while (!finished && !aborted && cyc < 4000) begin
      if (clr_ar) begin i_arvalid = 1'b0; clr_ar = 0; end
      if (clr_mr) begin i_m_rvalid = 1'b0; pend = 0; clr_mr = 0; end
      i_m_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend && !i_m_rvalid) begin
        if (dly == 0) begin
          i_m_rvalid = 1'b1;
          i_m_rdata  = exp_data[ar_cnt-1];
          i_m_rresp  = exp_resp[ar_cnt-1];
        end else dly--;
      end
      i_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_rvalid && r_cnt == stall_beat && stall_left > 0) begin i_rready = 1'b0; stall_left--; end
      if (o_rvalid && r_cnt == abort_beat) begin i_rst = 1'b1; i_rready = 1'b0; end
      #1;
      nvalid = int'(o_arready) + int'(o_m_arvalid) + int'(o_m_rready) + int'(o_rvalid);
      total++; if (nvalid > 1) begin bad++; $display("FAIL exclusive_valids got=%0d exp<=1 cyc=%0d", nvalid, cyc); end
      if (i_arvalid && o_arready) begin
        hs_cnt++; hs_cyc = cyc;
        total++; if (hs_cnt != 1) begin bad++; $display("FAIL ar_accept_count got=%0d exp=1", hs_cnt); end
        if (!hold_ar) clr_ar = 1;
      end
      if (o_m_arvalid && !seen_ar) begin
        seen_ar = 1;
        total++; if (cyc != hs_cyc + 1) begin bad++; $display("FAIL m_arvalid_latency got=%0d exp=%0d", cyc - hs_cyc, 1); end
      end
      if (o_m_arvalid && i_m_arready) begin
        total++;
        if (ar_cnt >= n) begin
          bad++; $display("FAIL extra_m_ar got=%0d exp=%0d", ar_cnt + 1, n);
        end else begin
          if (o_m_araddr !== exp_addr[ar_cnt]) begin bad++; $display("FAIL m_araddr beat=%0d got=%h exp=%h", ar_cnt, o_m_araddr, exp_addr[ar_cnt]); end
          total++; if (o_m_arsize !== 3'(eff)) begin bad++; $display("FAIL m_arsize got=%0d exp=%0d", o_m_arsize, eff); end
          total++; if (o_m_arlen !== 8'd0 || o_m_arburst !== 2'b01) begin bad++; $display("FAIL m_arlen_burst got=%h/%b exp=00/01", o_m_arlen, o_m_arburst); end
          total++; if (o_m_arid !== id) begin bad++; $display("FAIL m_arid got=%b exp=%b", o_m_arid, id); end
          exp_data.push_back({$urandom, $urandom});
          exp_resp.push_back((ar_cnt == err_beat) ? 2'b10 : (rnd ? 2'($urandom_range(0, 3)) : 2'b00));
          dly = rnd ? $urandom_range(0, 3) : 0;
          pend = 1;
          ar_cnt++;
        end
      end
      if (i_m_rvalid && o_m_rready) clr_mr = 1;
      if (o_rvalid) begin
        if (prev_hold) begin
          total++;
          if (o_rdata !== prev_data || o_rresp !== prev_resp || o_rlast !== prev_last) begin
            bad++; $display("FAIL r_stable got=%h/%b/%b exp=%h/%b/%b", o_rdata, o_rresp, o_rlast, prev_data, prev_resp, prev_last);
          end
        end
        if (i_rst) aborted = 1;
        else if (i_rready) begin
          total++; if (o_rdata !== exp_data[r_cnt]) begin bad++; $display("FAIL rdata beat=%0d got=%h exp=%h", r_cnt, o_rdata, exp_data[r_cnt]); end
          total++; if (o_rresp !== exp_resp[r_cnt]) begin bad++; $display("FAIL rresp beat=%0d got=%b exp=%b", r_cnt, o_rresp, exp_resp[r_cnt]); end
          total++; if (o_rlast !== (r_cnt == n - 1)) begin bad++; $display("FAIL rlast beat=%0d got=%b exp=%b", r_cnt, o_rlast, (r_cnt == n - 1)); end
          total++; if (o_rid !== id) begin bad++; $display("FAIL rid got=%b exp=%b", o_rid, id); end
          r_cnt++;
          prev_hold = 0;
          if (r_cnt == n) finished = 1;
        end else begin
          prev_hold = 1; prev_data = o_rdata; prev_resp = o_rresp; prev_last = o_rlast;
        end
      end
      if (!finished && !aborted) begin @(negedge i_clk); cyc++; end
    end
    if (!finished && !aborted) begin
      total++; bad++; $display("FAIL burst_timeout got=%0d beats exp=%0d", r_cnt, n);
    end
    @(negedge i_clk);
    i_arvalid = 1'b0; i_rready = 1'b0; i_m_rvalid = 1'b0;
    #1;
    if (aborted) begin
      total++; if (o_rvalid !== 1'b0 || o_m_arvalid !== 1'b0) begin bad++; $display("FAIL abort_quiet got=%b/%b exp=0/0", o_rvalid, o_m_arvalid); end
      total++; if (o_arready !== 1'b0) begin bad++; $display("FAIL abort_arready_in_rst got=%b exp=0", o_arready); end
      i_rst = 1'b0;
      #1;
      total++; if (o_arready !== 1'b1) begin bad++; $display("FAIL abort_arready_after got=%b exp=1", o_arready); end
    end else begin
      total++; if (o_arready !== 1'b1 || o_rvalid !== 1'b0) begin bad++; $display("FAIL end_idle got=%b/%b exp=1/0", o_arready, o_rvalid); end
      total++; if (ar_cnt != n) begin bad++; $display("FAIL m_ar_count got=%0d exp=%0d", ar_cnt, n); end
      @(negedge i_clk);
      total++; if (o_m_arvalid !== 1'b0) begin bad++; $display("FAIL stray_m_ar got=%b exp=0", o_m_arvalid); end
    end
  endtask

  task automatic test_incr();
    run_burst(1'b1, 32'h100, 3, 3, 2'b01, -1, 0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst(1'b0, 32'h118, 3, 3, 2'b10, -1, 0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_fixed_stall();
    run_burst(1'b1, 32'h40, 2, 3, 2'b00, 1, 5, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_slverr();
    run_burst(1'b0, 32'h103, 1, 2, 2'b01, -1, 0, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_burst(1'b1, 32'h200, 7, 3, 2'b01, -1, 0, -1, 2, 1'b0, 1'b0);
    run_burst(1'b0, 32'h300, 7, 3, 2'b01, -1, 0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_len255();
    run_burst(1'b1, 32'hFFFF_FF00, 255, 3, 2'b01, -1, 0, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      run_burst(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 15), $urandom_range(0, 7),
                2'($urandom_range(0, 3)), -1, 0, -1, -1, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_slverr();
    test_reset_mid();
    test_len255();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
